// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit:
// scoreboard entry layout, field offsets and select encoding.
package fwd_hazard_unit_pkg;

  localparam int RA_W_DEF = 3;

  // Entry layout, MSB to LSB: {valid, wb, rd, is_load}
  typedef struct packed {
    logic                valid;
    logic                wb;
    logic [RA_W_DEF-1:0] rd;
    logic                is_load;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);

  // Bit offsets inside a flattened entry of arbitrary register width
  localparam int ENT_LOAD = 0;
  localparam int ENT_RD   = 1;

  function automatic int ent_w(input int ra_w);
    return ra_w + 3;
  endfunction

  function automatic int ent_wb(input int ra_w);
    return ra_w + 1;
  endfunction

  function automatic int ent_valid(input int ra_w);
    return ra_w + 2;
  endfunction

  // Select encoding: 0 = register file, s = post-EX stage s
  localparam int SEL_RF = 0;

  function automatic int sel_stage(input int s);
    return s;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_match_prio.sv
// Youngest-match priority finder: scans scoreboard positions FIRST..LAST
// for a valid writer of rsrc and reports the lowest matching position.
module fwd_match_prio
  import fwd_hazard_unit_pkg::*;
#(
  parameter int RA_W      = RA_W_DEF,
  parameter int FWD_DEPTH = 2,
  parameter int FIRST     = 1,
  parameter int LAST      = 2,
  localparam int SEL_W    = $clog2(FWD_DEPTH + 1),
  localparam int EW       = RA_W + 3
) (
  input  logic [RA_W-1:0]              rsrc,
  input  logic [(FWD_DEPTH+1)*EW-1:0]  sb,
  output logic                         hit,
  output logic [SEL_W-1:0]             idx,
  output logic                         is_load
);

  // Oldest to youngest so the lowest matching position overwrites older hits
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int p = FWD_DEPTH; p >= 0; p--) begin
      if (p >= FIRST && p <= LAST &&
          sb[p*EW + ent_valid(RA_W)] && sb[p*EW + ent_wb(RA_W)] &&
          sb[p*EW + ENT_RD +: RA_W] == rsrc) begin
        hit     = 1'b1;
        idx     = SEL_W'(sel_stage(p));
        is_load = sb[p*EW + ENT_LOAD];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select generator with load-use stall detection.
// Shift-register scoreboard: position 0 = EX, 1..FWD_DEPTH = post-EX stages.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int RA_W       = RA_W_DEF,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_READY = 2,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*RA_W-1:0]   id_rsrc_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  input  logic                      id_wb_i,
  input  logic [RA_W-1:0]           id_rdst_i,
  input  logic                      id_is_load_i,
  input  logic                      hold_i,
  input  logic                      flush_i,
  output logic [NUM_SRC*SEL_W-1:0]  exec_sel_o,
  output logic                      stall_o,
  output logic                      ex_valid_o
);

  localparam int EW   = ent_w(RA_W);
  localparam int SB_W = (FWD_DEPTH + 1) * EW;

  logic [SB_W-1:0]          sb_q;
  logic [NUM_SRC*RA_W-1:0]  ex_rsrc_q;
  logic [NUM_SRC-1:0]       ex_used_q;

  logic                     issue;
  logic [EW-1:0]            new_entry;
  logic [NUM_SRC-1:0]       stall_src;

  logic [NUM_SRC-1:0]       ex_hit, ex_ld, id_hit, id_ld;
  logic [SEL_W-1:0]         ex_idx [NUM_SRC];
  logic [SEL_W-1:0]         id_idx [NUM_SRC];

  assign issue     = id_valid_i & ~stall_o & ~flush_i;
  assign new_entry = issue ? {1'b1, id_wb_i, id_rdst_i, id_is_load_i} : '0;

  // Advance the scoreboard one stage per unheld edge; oldest entry falls off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q      <= '0;
      ex_rsrc_q <= '0;
      ex_used_q <= '0;
    end else if (!hold_i) begin
      sb_q      <= {sb_q[SB_W-EW-1:0], new_entry};
      ex_rsrc_q <= id_rsrc_i;
      ex_used_q <= issue ? id_src_used_i : '0;
    end
  end

  assign ex_valid_o = sb_q[ent_valid(RA_W)];

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_match_prio #(
      .RA_W(RA_W), .FWD_DEPTH(FWD_DEPTH), .FIRST(1), .LAST(FWD_DEPTH)
    ) u_ex_match (
      .rsrc    (ex_rsrc_q[k*RA_W +: RA_W]),
      .sb      (sb_q),
      .hit     (ex_hit[k]),
      .idx     (ex_idx[k]),
      .is_load (ex_ld[k])
    );

    fwd_match_prio #(
      .RA_W(RA_W), .FWD_DEPTH(FWD_DEPTH), .FIRST(0), .LAST(FWD_DEPTH-1)
    ) u_id_match (
      .rsrc    (id_rsrc_i[k*RA_W +: RA_W]),
      .sb      (sb_q),
      .hit     (id_hit[k]),
      .idx     (id_idx[k]),
      .is_load (id_ld[k])
    );

    // A load not yet at LOAD_READY has no data; the stall keeps this case away
    assign exec_sel_o[k*SEL_W +: SEL_W] =
      (ex_used_q[k] && ex_hit[k] && !(ex_ld[k] && int'(ex_idx[k]) < LOAD_READY))
        ? ex_idx[k] : SEL_W'(SEL_RF);

    // The load will be at p+1 when this instruction reaches EX
    assign stall_src[k] = id_src_used_i[k] & id_hit[k] & id_ld[k] &
                          ((int'(id_idx[k]) + 1) < LOAD_READY);
  end

  assign stall_o = id_valid_i & ~flush_i & (|stall_src);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed rows push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0, id_valid3 = 1'b0;
  logic [5:0] id_rsrc = '0;
  logic [1:0] id_used = '0;
  logic       id_wb = 1'b0;
  logic [2:0] id_rdst = '0;
  logic       id_ld = 1'b0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;

  logic [3:0] exec_sel, exec_sel3;
  logic       stall, stall3, ex_valid, ex_valid3;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rsrc_i(id_rsrc),
    .id_src_used_i(id_used), .id_wb_i(id_wb), .id_rdst_i(id_rdst),
    .id_is_load_i(id_ld), .hold_i(hold), .flush_i(flush),
    .exec_sel_o(exec_sel), .stall_o(stall), .ex_valid_o(ex_valid)
  );

  fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_READY(3)) dut3 (
    .clk(clk), .rst(rst), .id_valid_i(id_valid3), .id_rsrc_i(id_rsrc),
    .id_src_used_i(id_used), .id_wb_i(id_wb), .id_rdst_i(id_rdst),
    .id_is_load_i(id_ld), .hold_i(hold), .flush_i(flush),
    .exec_sel_o(exec_sel3), .stall_o(stall3), .ex_valid_o(ex_valid3)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit stall;
    bit exv;
    bit c3;
    bit stall3;
  } cyc_t;

  cyc_t     cyc_q[$];
  bit [3:0] ex_q[$];
  bit [3:0] ex3_q[$];

  int checks = 0;
  int errors = 0;
  bit adv;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Tracks whether EX took new contents at the last edge
  always @(posedge clk or posedge rst) begin
    if (rst) adv <= 1'b0;
    else     adv <= !hold;
  end

  // Monitor: per-cycle stall/valid expectations and per-instruction selects
  always @(negedge clk) begin
    cyc_t c;
    bit [3:0] e;
    if (!rst) begin
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("stall", int'(stall), int'(c.stall));
        chk("ex_valid", int'(ex_valid), int'(c.exv));
        if (c.c3) chk("stall_lr3", int'(stall3), int'(c.stall3));
      end
      if (adv && ex_valid) begin
        if (ex_q.size() == 0) chk("ex_q_underflow", 1, 0);
        else begin
          e = ex_q.pop_front();
          chk("exec_sel", int'(exec_sel), int'(e));
        end
      end
      if (adv && ex_valid3) begin
        if (ex3_q.size() == 0) chk("ex3_q_underflow", 1, 0);
        else begin
          e = ex3_q.pop_front();
          chk("exec_sel_lr3", int'(exec_sel3), int'(e));
        end
      end
    end
  end

  // One cycle of stimulus plus its hand-computed expectations
  task automatic step(input bit v, input bit v3, input bit [2:0] rs1, input bit [2:0] rs2,
                      input bit [1:0] used, input bit wb, input bit [2:0] rd, input bit ld,
                      input bit hd, input bit fl, input bit es, input bit ex,
                      input bit c3, input bit es3, input bit [1:0] s1, input bit [1:0] s2);
    cyc_t c;
    @(posedge clk);
    #1;
    id_valid = v; id_valid3 = v3; id_rsrc = {rs2, rs1}; id_used = used;
    id_wb = wb; id_rdst = rd; id_ld = ld; hold = hd; flush = fl;
    c.stall = es; c.exv = ex; c.c3 = c3; c.stall3 = es3;
    cyc_q.push_back(c);
    if (v && !es && !fl && !hd)   ex_q.push_back({s2, s1});
    if (v3 && !es3 && !fl && !hd) ex3_q.push_back({s2, s1});
  endtask

  initial begin
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_exec_sel", int'(exec_sel), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_ex_valid", int'(ex_valid), 0);
    @(negedge clk) rst = 1'b0;

    //    v v3 rs1 rs2 used wb rd ld hd fl es ex c3 es3 s1 s2
    // 1: ADD R1<-R2,R3 ; SUB R4<-R1,R5
    step(1, 0, 2, 3, 2'b11, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 5, 2'b11, 1, 4, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    // 2: writer R1, unrelated, reader R1 as src2 ; two writers then reader
    step(1, 0, 6, 6, 2'b01, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 7, 7, 2'b00, 1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    step(1, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    // 3: LDD R4 ; ADD R5<-R3,R4 stalls one cycle
    step(1, 0, 2, 0, 2'b01, 1, 4, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 3, 4, 2'b11, 1, 5, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 3, 4, 2'b11, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    // 4: LDD R4 ; MOV R4<-R6 ; reader R4 forwards from MOV
    step(1, 0, 0, 0, 2'b00, 1, 4, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 6, 0, 2'b01, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    // 5a: load-use with flush -> no stall, bubble in EX
    step(1, 0, 0, 0, 2'b00, 1, 3, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 3, 0, 2'b01, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // 5b: load-use stall frozen by hold for 3 cycles
    step(1, 0, 0, 0, 2'b00, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 2, 2'b10, 1, 6, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 2, 2'b10, 1, 6, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 2, 2'b10, 1, 6, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 2, 2'b10, 1, 6, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 2, 2'b10, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    // 6a: fill scoreboard, LDD R5<-[R1] forwards from MEM, dependent stalls
    step(1, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 2'b01, 1, 5, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    step(1, 0, 5, 0, 2'b01, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

    // Reset mid-stall: outputs must clear before the next edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_exec_sel", int'(exec_sel), 0);
    chk("midrst_stall", int'(stall), 0);
    chk("midrst_ex_valid", int'(ex_valid), 0);
    id_valid = 1'b0;
    ex_q.delete();
    ex3_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;

    // 6b: LOAD_READY=3 variant, dependent stalls two cycles then gets sel=3
    step(0, 1, 0, 0, 2'b00, 1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 4, 2'b10, 1, 5, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 4, 2'b10, 1, 5, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 4, 2'b10, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0, 3);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("ex_q_drained", ex_q.size(), 0);
    chk("ex3_q_drained", ex3_q.size(), 0);
    chk("cyc_q_drained", cyc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
